// File: rtl/lpgbt_downlink_sequencer.sv
// lpgbt_downlink_sequencer
//   Downlink playback buffer for the lpGBT-FPGA downlink core. Register writes
//   load 32-bit user words into a small buffer. The buffer is then played out
//   one word per downlink frame, either once or in a continuous loop. When no
//   buffered word is due, IDLE_WORD is sent.
//
// Ports
//   S_AXI_ACLK          single clock; frame_strobe is synchronous to it
//   S_AXI_ARESETN       asynchronous active-low reset
//   wr_data             register write data
//   wr_fifo_strobe      push wr_data into the buffer
//   wr_ctrl_strobe      load the control register from wr_data
//   ctrl_rd             control readback (bit2, the clear pulse, reads 0)
//   status_rd           [15:0] count, [16] overflow, [17] wr_err,
//                       [19:18] state, [31:24] loop count
//   frame_strobe        one-cycle pulse per downlink frame
//   downlink_ready      downlink core ready; frames without it are stalls
//   downlinkUserData_o  user word, registered at each frame_strobe
//   downlinkEcData_o    EC field (ctrl[5:4])
//   downlinkIcData_o    IC field (ctrl[7:6])
//   downlink_valid_o    held word came from the buffer
//   busy_o              playback in progress
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for enable with a non-empty buffer; loading allowed
// RUN   | playing buffer words on ready frames; loading rejected
// DONE  | single-shot finished, sending idle; loading allowed
module lpgbt_downlink_sequencer #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          DEPTH              = 64,
  parameter logic [31:0] IDLE_WORD          = 32'h0000_0000
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data,
  input  logic                          wr_fifo_strobe,
  input  logic                          wr_ctrl_strobe,
  output logic [31:0]                   ctrl_rd,
  output logic [31:0]                   status_rd,
  input  logic                          frame_strobe,
  input  logic                          downlink_ready,
  output logic [31:0]                   downlinkUserData_o,
  output logic [1:0]                    downlinkEcData_o,
  output logic [1:0]                    downlinkIcData_o,
  output logic                          downlink_valid_o,
  output logic                          busy_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     ctrl_q, ctrl_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic            werr_q, werr_d;
  logic [7:0]      loop_q, loop_d;
  logic [31:0]     user_q, user_d;
  logic [1:0]      ec_q, ec_d;
  logic [1:0]      ic_q, ic_d;
  logic            valid_q, valid_d;

  logic [31:0]     mem_q [DEPTH];

  logic            clear;
  logic            can_load;
  logic            full;
  logic            push_ok;
  logic            send;
  logic            last;
  logic [31:0]     rd_word;

  // The control value written this cycle is acted on immediately so that
  // an enable write moves IDLE->RUN on the very next edge.
  assign clear    = wr_ctrl_strobe & wr_data[2];
  assign ctrl_d   = wr_ctrl_strobe ? {wr_data[31:3], 1'b0, wr_data[1:0]} : ctrl_q;
  assign can_load = (state_q == IDLE) || (state_q == DONE);
  assign full     = (count_q >= DEPTH_C);
  assign push_ok  = wr_fifo_strobe & ~clear & can_load & ~full;
  assign send     = (state_q == RUN) & ctrl_d[0] & ~clear & frame_strobe & downlink_ready;
  assign last     = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));
  assign rd_word  = mem_q[rd_ptr_q];

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    werr_d   = werr_q;
    loop_d   = loop_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl_d[0] && (count_q != '0)) begin
          state_d  = RUN;
          rd_ptr_d = '0;
        end
      end
      RUN: begin
        if (!ctrl_d[0]) begin
          state_d = IDLE;
        end else if (send) begin
          if (last) begin
            if (ctrl_d[1]) begin
              rd_ptr_d = '0;
              loop_d   = loop_q + 8'd1;
            end else begin
              state_d = DONE;
            end
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end
        end
      end
      DONE: begin
        if (!ctrl_d[0]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (push_ok) count_d = count_q + CW'(1);

    // A push that collides with a clear is silently dropped.
    if (wr_fifo_strobe && !clear) begin
      if (can_load && full) ovf_d = 1'b1;
      if (state_q == RUN)   werr_d = 1'b1;
    end

    if (clear) begin
      state_d  = IDLE;
      count_d  = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      werr_d   = 1'b0;
      loop_d   = '0;
    end
  end

  // Frame outputs only change on frame_strobe and hold in between.
  always_comb begin
    user_d  = user_q;
    valid_d = valid_q;
    ec_d    = ec_q;
    ic_d    = ic_q;
    if (frame_strobe) begin
      user_d  = send ? rd_word : IDLE_WORD;
      valid_d = send;
      ec_d    = ctrl_q[5:4];
      ic_d    = ctrl_q[7:6];
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      count_q  <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      werr_q   <= 1'b0;
      loop_q   <= '0;
      user_q   <= IDLE_WORD;
      ec_q     <= '0;
      ic_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      werr_q   <= werr_d;
      loop_q   <= loop_d;
      user_q   <= user_d;
      ec_q     <= ec_d;
      ic_q     <= ic_d;
      valid_q  <= valid_d;
    end
  end

  // Buffer storage has no reset; only words below count are ever read.
  always_ff @(posedge S_AXI_ACLK) begin
    if (push_ok) mem_q[count_q[AW-1:0]] <= wr_data[31:0];
  end

  assign ctrl_rd            = ctrl_q;
  assign status_rd          = {loop_q, 4'b0000, state_q, werr_q, ovf_q, 16'(count_q)};
  assign downlinkUserData_o = user_q;
  assign downlinkEcData_o   = ec_q;
  assign downlinkIcData_o   = ic_q;
  assign downlink_valid_o   = valid_q;
  assign busy_o             = (state_q == RUN);

endmodule

// File: tb/tb_lpgbt_downlink_sequencer.sv
module tb_lpgbt_downlink_sequencer;

  localparam logic [31:0] IDLE_W = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_fifo_strobe = 1'b0;
  logic        wr_ctrl_strobe = 1'b0;
  logic        frame_strobe = 1'b0;
  logic        downlink_ready = 1'b1;
  logic [31:0] ctrl_rd, status_rd, user;
  logic [1:0]  ec, ic;
  logic        valid, busy;

  always #5 clk = ~clk;

  lpgbt_downlink_sequencer #(
    .C_S_AXI_DATA_WIDTH(32),
    .DEPTH(64),
    .IDLE_WORD(IDLE_W)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .wr_data(wr_data),
    .wr_fifo_strobe(wr_fifo_strobe),
    .wr_ctrl_strobe(wr_ctrl_strobe),
    .ctrl_rd(ctrl_rd),
    .status_rd(status_rd),
    .frame_strobe(frame_strobe),
    .downlink_ready(downlink_ready),
    .downlinkUserData_o(user),
    .downlinkEcData_o(ec),
    .downlinkIcData_o(ic),
    .downlink_valid_o(valid),
    .busy_o(busy)
  );

  typedef struct packed {
    logic [31:0] w;
    logic        v;
    logic [1:0]  ec;
    logic [1:0]  ic;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w);
    @(negedge clk);
    wr_data = w; wr_fifo_strobe = 1'b1;
    @(negedge clk);
    wr_fifo_strobe = 1'b0;
  endtask

  task automatic ctrl_wr(input logic [31:0] v);
    @(negedge clk);
    wr_data = v; wr_ctrl_strobe = 1'b1;
    @(negedge clk);
    wr_ctrl_strobe = 1'b0;
  endtask

  task automatic fstrobe(input logic [31:0] w, input logic v, input logic [1:0] e, input logic [1:0] i);
    exp_t x;
    x.w = w; x.v = v; x.ec = e; x.ic = i;
    @(negedge clk);
    frame_strobe = 1'b1;
    exp_q.push_back(x);
    @(negedge clk);
    frame_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Monitor: outputs are presented the cycle after each sampled frame_strobe.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      if (frame_strobe && rst_n) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_unexpected: got %h with no expected entry", user);
        end else begin
          e = exp_q.pop_front();
          chk("frame_out", {user, valid, ec, ic}, {e.w, e.v, e.ec, e.ic});
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 1: idle after reset
    repeat (4) fstrobe(IDLE_W, 1'b0, 2'd0, 2'd0);
    chk("t1_status", 37'(status_rd), 37'h0);
    chk("t1_ctrl", 37'(ctrl_rd), 37'h0);

    // 2: single shot
    push(32'hA000_0001); push(32'hA000_0002); push(32'hA000_0003);
    ctrl_wr(32'h01);
    fstrobe(32'hA000_0001, 1'b1, 2'd0, 2'd0);
    fstrobe(32'hA000_0002, 1'b1, 2'd0, 2'd0);
    fstrobe(32'hA000_0003, 1'b1, 2'd0, 2'd0);
    fstrobe(IDLE_W, 1'b0, 2'd0, 2'd0);
    fstrobe(IDLE_W, 1'b0, 2'd0, 2'd0);
    chk("t2_status", 37'(status_rd), 37'h0008_0003);
    chk("t2_ctrl", 37'(ctrl_rd), 37'h1);

    // 3: loop playback, then disable
    ctrl_wr(32'h04);
    push(32'hB000_0001); push(32'hB000_0002);
    ctrl_wr(32'h03);
    fstrobe(32'hB000_0001, 1'b1, 2'd0, 2'd0);
    fstrobe(32'hB000_0002, 1'b1, 2'd0, 2'd0);
    fstrobe(32'hB000_0001, 1'b1, 2'd0, 2'd0);
    fstrobe(32'hB000_0002, 1'b1, 2'd0, 2'd0);
    fstrobe(32'hB000_0001, 1'b1, 2'd0, 2'd0);
    chk("t3_status_run", 37'(status_rd), 37'h0204_0002);
    chk("t3_busy", 37'(busy), 37'h1);
    ctrl_wr(32'h02);
    chk("t3_status_idle", 37'(status_rd), 37'h0200_0002);
    fstrobe(IDLE_W, 1'b0, 2'd0, 2'd0);

    // 4: overflow at DEPTH, write error in RUN, full playback
    ctrl_wr(32'h04);
    for (int i = 0; i < 65; i++) push(32'hD000_0000 + 32'(i));
    chk("t4_overflow", 37'(status_rd), 37'h0001_0040);
    ctrl_wr(32'h01);
    push(32'hDEAD_BEEF);
    chk("t4_wr_err", 37'(status_rd), 37'h0007_0040);
    for (int i = 0; i < 64; i++) fstrobe(32'hD000_0000 + 32'(i), 1'b1, 2'd0, 2'd0);
    fstrobe(IDLE_W, 1'b0, 2'd0, 2'd0);
    chk("t4_done", 37'(status_rd), 37'h000B_0040);

    // 5: stalls on downlink_ready, EC/IC fields
    ctrl_wr(32'h04);
    chk("t5_cleared", 37'(status_rd), 37'h0);
    push(32'hC000_0001); push(32'hC000_0002); push(32'hC000_0003);
    ctrl_wr(32'hD1);
    chk("t5_ctrl", 37'(ctrl_rd), 37'hD1);
    fstrobe(32'hC000_0001, 1'b1, 2'd1, 2'd3);
    downlink_ready = 1'b0;
    fstrobe(IDLE_W, 1'b0, 2'd1, 2'd3);
    fstrobe(IDLE_W, 1'b0, 2'd1, 2'd3);
    downlink_ready = 1'b1;
    fstrobe(32'hC000_0002, 1'b1, 2'd1, 2'd3);
    fstrobe(32'hC000_0003, 1'b1, 2'd1, 2'd3);
    fstrobe(IDLE_W, 1'b0, 2'd1, 2'd3);

    // 6: async reset mid-run, clear beats same-cycle push
    ctrl_wr(32'h04);
    push(32'hE000_0001); push(32'hE000_0002);
    ctrl_wr(32'h33);
    fstrobe(32'hE000_0001, 1'b1, 2'd3, 2'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_out", {user, valid, ec, ic}, {IDLE_W, 1'b0, 2'd0, 2'd0});
    chk("t6_rst_busy", 37'(busy), 37'h0);
    chk("t6_rst_status", 37'(status_rd), 37'h0);
    chk("t6_rst_ctrl", 37'(ctrl_rd), 37'h0);
    @(negedge clk);
    rst_n = 1'b1;
    push(32'hF000_0001);
    chk("t6_one_word", 37'(status_rd), 37'h1);
    @(negedge clk);
    wr_data = 32'h04; wr_ctrl_strobe = 1'b1; wr_fifo_strobe = 1'b1;
    @(negedge clk);
    wr_ctrl_strobe = 1'b0; wr_fifo_strobe = 1'b0;
    chk("t6_clear_push", 37'(status_rd), 37'h0);
    chk("t6_clear_ctrl", 37'(ctrl_rd), 37'h0);
    ctrl_wr(32'h01);
    fstrobe(IDLE_W, 1'b0, 2'd0, 2'd0);
    chk("t6_empty_enable", 37'(status_rd), 37'h0);
    chk("t6_empty_busy", 37'(busy), 37'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 37'(exp_q.size()), 37'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
